// File: rtl/frame_buffer_arbiter.sv
// Triple-buffered frame scheduler: shares one memory command port between the camera
// write path and the display read path, and rotates three frame banks between them.
module frame_buffer_arbiter #(
    parameter int OFS_W       = 20,
    parameter int FRAME_WORDS = 921600,
    parameter int BURST_LEN   = 32,
    parameter int LVL_W       = 10,
    parameter int RD_DEPTH    = 512,
    parameter int WR_URGENT   = 384
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_wr_frame_start,
    input  logic             I_rd_frame_start,
    input  logic [LVL_W-1:0] I_wr_fifo_level,
    input  logic [LVL_W-1:0] I_rd_fifo_level,
    output logic             O_cmd_valid,
    input  logic             I_cmd_ready,
    output logic             O_cmd_we,
    output logic [OFS_W+1:0] O_cmd_addr,
    input  logic             I_burst_done,
    output logic [1:0]       O_wr_bank,
    output logic [1:0]       O_rd_bank,
    output logic             O_latest_valid,
    output logic [7:0]       O_drop_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_t;

    localparam int CNT_W = OFS_W + 1;
    localparam logic [CNT_W-1:0]   C_FRAME    = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]   C_BURST    = CNT_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]   C_WR_MIN   = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0]   C_WR_URG   = LVL_W'(WR_URGENT);
    localparam logic [LVL_W+1:0]   C_RD_LIMIT = (LVL_W+2)'(RD_DEPTH - BURST_LEN);

    state_t           r_state;
    logic             r_wr_pend, r_rd_pend;
    logic             r_wr_active, r_rd_active;
    logic [CNT_W-1:0] r_wr_ofs, r_rd_ofs;
    logic [1:0]       r_wr_bank, r_rd_bank, r_latest;
    logic             r_latest_valid;
    logic [7:0]       r_drop_cnt;
    logic             r_cmd_valid, r_cmd_we;
    logic [OFS_W+1:0] r_cmd_addr;

    logic             w_apply, w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
    logic [1:0]       w_rd_bank_nxt;

    // Lowest bank that is neither being displayed nor holding the newest frame.
    function automatic logic [1:0] f_pick_wr_bank(input logic [1:0] rd, input logic [1:0] lt,
                                                  input logic lv);
        if (rd != 2'd0 && !(lv && lt == 2'd0))
            return 2'd0;
        else if (rd != 2'd1 && !(lv && lt == 2'd1))
            return 2'd1;
        else
            return 2'd2;
    endfunction

    assign w_apply       = (r_state == S_IDLE) && (r_wr_pend || r_rd_pend);
    assign w_rd_bank_nxt = (r_rd_pend && r_latest_valid) ? r_latest : r_rd_bank;
    assign w_wr_elig     = r_wr_active && (r_wr_ofs < C_FRAME) && (I_wr_fifo_level >= C_WR_MIN);
    assign w_rd_elig     = r_rd_active && (r_rd_ofs < C_FRAME) &&
                           ({2'b00, I_rd_fifo_level} <= C_RD_LIMIT);
    assign w_grant_wr    = w_wr_elig && ((I_wr_fifo_level >= C_WR_URG) || !w_rd_elig);
    assign w_grant_rd    = w_rd_elig && !w_grant_wr;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state        <= S_IDLE;
            r_wr_pend      <= 1'b0;
            r_rd_pend      <= 1'b0;
            r_wr_active    <= 1'b0;
            r_rd_active    <= 1'b0;
            r_wr_ofs       <= '0;
            r_rd_ofs       <= '0;
            r_wr_bank      <= 2'd1;
            r_rd_bank      <= 2'd0;
            r_latest       <= 2'd0;
            r_latest_valid <= 1'b0;
            r_drop_cnt     <= 8'd0;
            r_cmd_valid    <= 1'b0;
            r_cmd_we       <= 1'b0;
            r_cmd_addr     <= '0;
        end else begin
            // A pulse landing on an already-set flag merges with it.
            r_rd_pend <= r_rd_pend ? !w_apply : I_rd_frame_start;
            r_wr_pend <= r_wr_pend ? !w_apply : I_wr_frame_start;
            case (r_state)
                S_IDLE: begin
                    if (w_apply) begin
                        if (r_rd_pend) begin
                            r_rd_bank   <= w_rd_bank_nxt;
                            r_rd_ofs    <= '0;
                            r_rd_active <= 1'b1;
                        end
                        if (r_wr_pend) begin
                            if (r_wr_active && r_wr_ofs < C_FRAME && r_drop_cnt != 8'hFF)
                                r_drop_cnt <= r_drop_cnt + 8'd1;
                            r_wr_bank   <= f_pick_wr_bank(w_rd_bank_nxt, r_latest, r_latest_valid);
                            r_wr_ofs    <= '0;
                            r_wr_active <= 1'b1;
                        end
                    end else if (w_grant_wr || w_grant_rd) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= w_grant_wr;
                        r_cmd_addr  <= w_grant_wr ? {r_wr_bank, r_wr_ofs[OFS_W-1:0]}
                                                  : {r_rd_bank, r_rd_ofs[OFS_W-1:0]};
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (I_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        if (r_cmd_we)
                            r_wr_ofs <= r_wr_ofs + C_BURST;
                        else
                            r_rd_ofs <= r_rd_ofs + C_BURST;
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (I_burst_done) begin
                        if (r_cmd_we && r_wr_ofs == C_FRAME) begin
                            r_latest       <= r_wr_bank;
                            r_latest_valid <= 1'b1;
                            r_wr_active    <= 1'b0;
                        end
                        if (!r_cmd_we && r_rd_ofs == C_FRAME)
                            r_rd_active <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign O_cmd_valid    = r_cmd_valid;
    assign O_cmd_we       = r_cmd_we;
    assign O_cmd_addr     = r_cmd_addr;
    assign O_wr_bank      = r_wr_bank;
    assign O_rd_bank      = r_rd_bank;
    assign O_latest_valid = r_latest_valid;
    assign O_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Randomized bench for frame_buffer_arbiter: acts as memory controller and checks every
// command and the bank state against a transaction-level model of the bank rotation rules.
module tb_frame_buffer_arbiter;
    localparam int OFS_W = 20;
    localparam int FW    = 64;
    localparam int BL    = 32;
    localparam int LVL_W = 10;
    localparam int RDD   = 512;
    localparam int URG   = 384;

    logic             I_clk = 1'b0;
    logic             I_rst = 1'b1;
    logic             I_wr_frame_start = 1'b0;
    logic             I_rd_frame_start = 1'b0;
    logic [LVL_W-1:0] I_wr_fifo_level = '0;
    logic [LVL_W-1:0] I_rd_fifo_level = '0;
    logic             O_cmd_valid;
    logic             I_cmd_ready = 1'b0;
    logic             O_cmd_we;
    logic [OFS_W+1:0] O_cmd_addr;
    logic             I_burst_done = 1'b0;
    logic [1:0]       O_wr_bank, O_rd_bank;
    logic             O_latest_valid;
    logic [7:0]       O_drop_cnt;

    frame_buffer_arbiter #(
        .OFS_W(OFS_W), .FRAME_WORDS(FW), .BURST_LEN(BL),
        .LVL_W(LVL_W), .RD_DEPTH(RDD), .WR_URGENT(URG)
    ) dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_wr_frame_start(I_wr_frame_start), .I_rd_frame_start(I_rd_frame_start),
        .I_wr_fifo_level(I_wr_fifo_level), .I_rd_fifo_level(I_rd_fifo_level),
        .O_cmd_valid(O_cmd_valid), .I_cmd_ready(I_cmd_ready), .O_cmd_we(O_cmd_we),
        .O_cmd_addr(O_cmd_addr), .I_burst_done(I_burst_done),
        .O_wr_bank(O_wr_bank), .O_rd_bank(O_rd_bank),
        .O_latest_valid(O_latest_valid), .O_drop_cnt(O_drop_cnt)
    );

    always #5 I_clk = ~I_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers describing the frame bookkeeping.
    int m_wr_bank, m_rd_bank, m_latest, m_lv, m_drop;
    int m_wr_ofs, m_rd_ofs, m_wr_act, m_rd_act, m_pend_rd, m_pend_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic model_reset();
        m_wr_bank = 1; m_rd_bank = 0; m_latest = 0; m_lv = 0; m_drop = 0;
        m_wr_ofs = 0; m_rd_ofs = 0; m_wr_act = 0; m_rd_act = 0;
        m_pend_rd = 0; m_pend_wr = 0;
    endtask

    task automatic model_apply();
        if (m_pend_rd != 0) begin
            if (m_lv != 0) m_rd_bank = m_latest;
            m_rd_ofs = 0;
            m_rd_act = 1;
        end
        if (m_pend_wr != 0) begin
            if (m_wr_act != 0 && m_wr_ofs < FW && m_drop < 255) m_drop++;
            for (int b = 2; b >= 0; b--)
                if (b != m_rd_bank && !(m_lv != 0 && b == m_latest)) m_wr_bank = b;
            m_wr_ofs = 0;
            m_wr_act = 1;
        end
        m_pend_rd = 0;
        m_pend_wr = 0;
    endtask

    // 0 = nothing granted, 1 = write, 2 = read
    function automatic int predict(input int wl, input int rl);
        bit we, re;
        we = (m_wr_act != 0) && (m_wr_ofs < FW) && (wl >= BL);
        re = (m_rd_act != 0) && (m_rd_ofs < FW) && ((RDD - rl) >= BL);
        if (we && wl >= URG) return 1;
        if (re) return 2;
        if (we) return 1;
        return 0;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_wr_bank"}, 32'(O_wr_bank), 32'(m_wr_bank));
        chk({tag, "_rd_bank"}, 32'(O_rd_bank), 32'(m_rd_bank));
        chk({tag, "_latest_valid"}, 32'(O_latest_valid), 32'(m_lv));
        chk({tag, "_drop_cnt"}, 32'(O_drop_cnt), 32'(m_drop));
        if (m_wr_act != 0) chk({tag, "_wr_ne_rd"}, 32'(O_wr_bank != O_rd_bank), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(O_cmd_valid), 32'd0);
        chk({tag, "_we"}, 32'(O_cmd_we), 32'd0);
        chk({tag, "_addr"}, 32'(O_cmd_addr), 32'd0);
        check_state(tag);
    endtask

    task automatic inhibit();
        I_wr_fifo_level = '0;
        I_rd_fifo_level = LVL_W'(RDD);
    endtask

    task automatic pulse_starts(input bit rd, input bit wr);
        inhibit();
        I_rd_frame_start = rd;
        I_wr_frame_start = wr;
        step();
        I_rd_frame_start = 1'b0;
        I_wr_frame_start = 1'b0;
        step();
        step();
        m_pend_rd = m_pend_rd | int'(rd);
        m_pend_wr = m_pend_wr | int'(wr);
        model_apply();
        check_state("apply");
    endtask

    task automatic do_burst(input int wl, input int rl, input int stall, input int ddly,
                            input bit mrd, input bit mwr, input bit spur);
        int g, n, bank, ofs;
        logic [31:0] exp_addr;
        g = predict(wl, rl);
        I_wr_fifo_level = LVL_W'(wl);
        I_rd_fifo_level = LVL_W'(rl);
        if (g == 0) begin
            repeat (4) step();
            chk("idle_no_cmd", 32'(O_cmd_valid), 32'd0);
            inhibit();
            return;
        end
        n = 0;
        while (!O_cmd_valid && n < 8) begin
            step();
            n++;
        end
        chk("grant_latency", 32'(n), 32'd1);
        inhibit();
        bank = (g == 1) ? m_wr_bank : m_rd_bank;
        ofs  = (g == 1) ? m_wr_ofs : m_rd_ofs;
        exp_addr = 32'((bank << OFS_W) + ofs);
        chk("cmd_we", 32'(O_cmd_we), (g == 1) ? 32'd1 : 32'd0);
        chk("cmd_addr", 32'(O_cmd_addr), exp_addr);
        for (int s = 0; s < stall; s++) begin
            I_burst_done = spur;
            step();
            I_burst_done = 1'b0;
            chk("hold_valid", 32'(O_cmd_valid), 32'd1);
            chk("hold_addr", 32'(O_cmd_addr), exp_addr);
            chk("hold_we", 32'(O_cmd_we), (g == 1) ? 32'd1 : 32'd0);
        end
        I_cmd_ready = 1'b1;
        step();
        I_cmd_ready = 1'b0;
        chk("valid_drop", 32'(O_cmd_valid), 32'd0);
        if (g == 1) m_wr_ofs += BL; else m_rd_ofs += BL;
        if (mrd || mwr) begin
            I_rd_frame_start = mrd;
            I_wr_frame_start = mwr;
            step();
            I_rd_frame_start = 1'b0;
            I_wr_frame_start = 1'b0;
            m_pend_rd = m_pend_rd | int'(mrd);
            m_pend_wr = m_pend_wr | int'(mwr);
        end
        repeat (ddly) step();
        chk("one_outstanding", 32'(O_cmd_valid), 32'd0);
        I_burst_done = 1'b1;
        step();
        I_burst_done = 1'b0;
        if (g == 1 && m_wr_ofs == FW) begin
            m_latest = m_wr_bank;
            m_lv = 1;
            m_wr_act = 0;
        end
        if (g == 2 && m_rd_ofs == FW) m_rd_act = 0;
        step();
        step();
        model_apply();
        check_state("post_burst");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl_tab[7] = '{0, 31, 32, 100, 383, 384, 500};
        int rl_tab[6] = '{0, 100, 480, 481, 500, 512};
        model_reset();
        inhibit();
        I_rst = 1'b1;
        step();
        step();
        I_rst = 1'b0;
        check_reset("reset");

        // Write-only frame into bank 1, then publish and rotate.
        pulse_starts(1'b0, 1'b1);
        do_burst(32, RDD, 0, 4, 1'b0, 1'b0, 1'b0);
        do_burst(32, RDD, 0, 4, 1'b0, 1'b0, 1'b0);
        pulse_starts(1'b1, 1'b0);
        pulse_starts(1'b0, 1'b1);
        // Read beats a non-urgent write; urgent write beats read, with a stalled handshake.
        do_burst(100, 0, 0, 2, 1'b0, 1'b0, 1'b0);
        do_burst(384, 0, 5, 2, 1'b0, 1'b0, 1'b1);
        // Drop after half a frame, then both starts arriving during WAIT_DONE.
        pulse_starts(1'b0, 1'b1);
        do_burst(40, RDD, 1, 3, 1'b1, 1'b1, 1'b0);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                pulse_starts(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                do_burst(wl_tab[$urandom_range(0, 6)], rl_tab[$urandom_range(0, 5)],
                         $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
                         $urandom_range(0, 4) == 0);
            end
        end

        // Drop counter saturation.
        for (int k = 0; k < 260; k++) pulse_starts(1'b0, 1'b1);
        chk("drop_saturated", 32'(O_drop_cnt), 32'd255);

        // Reset while a write burst is in flight.
        pulse_starts(1'b0, 1'b1);
        I_wr_fifo_level = LVL_W'(32);
        step();
        step();
        inhibit();
        chk("pre_rst_valid", 32'(O_cmd_valid), 32'd1);
        I_cmd_ready = 1'b1;
        step();
        I_cmd_ready = 1'b0;
        I_rst = 1'b1;
        step();
        I_rst = 1'b0;
        model_reset();
        check_reset("midrst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
